// File: rtl/xgmii_rx_framer.sv
// XGMII receive framer: finds start-of-frame in lane 0 or lane 4, realigns the
// stream to 8-byte beats, strips preamble/SFD and terminate, and produces a
// stream of beats with tlast/tuser.
// Errors and oversize frames are flagged on the final beat.
module xgmii_rx_framer #(
  parameter int MAX_FRAME_BEATS = 192
) (
  input  logic        i_rxc,
  input  logic        i_rx_reset,
  input  logic [63:0] i_rxd,
  input  logic [7:0]  i_rxctl,
  input  logic        i_rx_valid,
  output logic [63:0] o_tdata,
  output logic [7:0]  o_tkeep,
  output logic        o_tvalid,
  output logic        o_tlast,
  output logic        o_tuser
);

  typedef enum logic [1:0] {IDLE, DATA, FLUSH, DISCARD} state_t;

  localparam logic [63:0] START_WORD = 64'hD555_5555_5555_55FB;
  localparam logic [7:0]  START_CTL  = 8'h01;
  localparam logic [7:0]  TERM_CHAR  = 8'hFD;
  // A non-final beat emitted when this many beats are already out would be
  // the last one allowed, so more data behind it means the frame is oversize.
  localparam logic [7:0]  CNT_LIMIT  = 8'(MAX_FRAME_BEATS - 1);

  state_t      state_reg, state_next;
  logic        mode4_reg, mode4_next;
  logic [31:0] prev_data_reg;
  logic [3:0]  prev_ctl_reg;
  logic [63:0] held_data_reg, held_data_next;
  logic [7:0]  held_keep_reg, held_keep_next;
  logic        held_valid_reg, held_valid_next;
  logic [7:0]  cnt_reg, cnt_next;

  logic [63:0] tdata_reg, tdata_next;
  logic [7:0]  tkeep_reg, tkeep_next;
  logic        tvalid_reg, tvalid_next;
  logic        tlast_reg, tlast_next;
  logic        tuser_reg, tuser_next;

  logic [63:0] shift_data;
  logic [7:0]  shift_ctl;
  logic [63:0] a_data;
  logic [7:0]  a_ctl;
  logic        cur_start;
  logic        shift_start;
  logic [2:0]  term_lane;
  logic [7:0]  term_char;
  logic [63:0] part_data;
  logic [7:0]  part_keep;

  logic        emit;
  logic        emit_last;
  logic        emit_user;
  logic        detect;

  // The word straddling the previous upper half and the current lower half.
  assign shift_data = {i_rxd[31:0], prev_data_reg};
  assign shift_ctl  = {i_rxctl[3:0], prev_ctl_reg};

  assign a_data = mode4_reg ? shift_data : i_rxd;
  assign a_ctl  = mode4_reg ? shift_ctl  : i_rxctl;

  assign cur_start   = (i_rxd == START_WORD) && (i_rxctl == START_CTL);
  assign shift_start = (shift_data == START_WORD) && (shift_ctl == START_CTL);

  // Lowest lane of the aligned word that carries a control character.
  always_comb begin
    term_lane = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (a_ctl[i]) term_lane = 3'(i);
    end
  end

  assign term_char = a_data[{term_lane, 3'b000} +: 8];

  // Bytes ahead of the terminate lane form the final partial beat; the rest
  // are zeroed so unused lanes never leak onto o_tdata.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_part
      assign part_keep[gi]          = (term_lane > 3'(gi));
      assign part_data[8*gi +: 8]   = part_keep[gi] ? a_data[8*gi +: 8] : 8'h00;
    end
  endgenerate

  // Next-state, held-beat and output decisions.
  always_comb begin
    state_next      = state_reg;
    mode4_next      = mode4_reg;
    held_data_next  = held_data_reg;
    held_keep_next  = held_keep_reg;
    held_valid_next = held_valid_reg;
    cnt_next        = cnt_reg;
    tdata_next      = 64'd0;
    tkeep_next      = 8'd0;
    tvalid_next     = 1'b0;
    tlast_next      = 1'b0;
    tuser_next      = 1'b0;
    emit            = 1'b0;
    emit_last       = 1'b0;
    emit_user       = 1'b0;
    detect          = 1'b0;

    case (state_reg)
      IDLE: begin
        detect = i_rx_valid;
      end

      DATA: begin
        if (i_rx_valid) begin
          if (a_ctl == 8'd0) begin
            // Full data beat: push out what is held, keep this one.
            held_data_next  = a_data;
            held_keep_next  = 8'hFF;
            held_valid_next = 1'b1;
            if (held_valid_reg) begin
              emit = 1'b1;
              if (cnt_reg >= CNT_LIMIT) begin
                emit_last       = 1'b1;
                emit_user       = 1'b1;
                held_valid_next = 1'b0;
                state_next      = DISCARD;
              end
            end
          end else if (term_char == TERM_CHAR) begin
            if (term_lane == 3'd0) begin
              // Frame ends on a beat boundary; nothing held means empty frame.
              emit            = held_valid_reg;
              emit_last       = 1'b1;
              held_valid_next = 1'b0;
              state_next      = IDLE;
            end else begin
              // Partial tail: hold it and flush it as the last beat next clock.
              held_data_next  = part_data;
              held_keep_next  = part_keep;
              held_valid_next = 1'b1;
              state_next      = FLUSH;
              if (held_valid_reg) begin
                emit = 1'b1;
                if (cnt_reg >= CNT_LIMIT) begin
                  emit_last       = 1'b1;
                  emit_user       = 1'b1;
                  held_valid_next = 1'b0;
                  state_next      = DISCARD;
                end
              end
            end
          end else begin
            // Unexpected control character: close the frame as errored.
            emit            = held_valid_reg;
            emit_last       = 1'b1;
            emit_user       = 1'b1;
            held_valid_next = 1'b0;
            state_next      = IDLE;
          end
        end
      end

      FLUSH: begin
        emit            = held_valid_reg;
        emit_last       = 1'b1;
        held_valid_next = 1'b0;
        state_next      = IDLE;
        detect          = i_rx_valid;
      end

      DISCARD: begin
        if (i_rx_valid && (i_rxctl != 8'd0)) begin
          state_next = IDLE;
          detect     = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (emit) begin
      tvalid_next = 1'b1;
      tdata_next  = held_data_reg;
      tkeep_next  = held_keep_reg;
      tlast_next  = emit_last;
      tuser_next  = emit_user;
      cnt_next    = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
    end

    // Start detection; lane 0 alignment takes precedence over lane 4.
    if (detect && (cur_start || shift_start)) begin
      state_next      = DATA;
      mode4_next      = !cur_start;
      cnt_next        = 8'd0;
      held_valid_next = 1'b0;
    end
  end

  // Framer state, alignment history and held beat.
  always_ff @(posedge i_rxc or posedge i_rx_reset) begin
    if (i_rx_reset) begin
      state_reg      <= IDLE;
      mode4_reg      <= 1'b0;
      prev_data_reg  <= 32'd0;
      prev_ctl_reg   <= 4'd0;
      held_data_reg  <= 64'd0;
      held_keep_reg  <= 8'd0;
      held_valid_reg <= 1'b0;
      cnt_reg        <= 8'd0;
    end else begin
      state_reg      <= state_next;
      mode4_reg      <= mode4_next;
      held_data_reg  <= held_data_next;
      held_keep_reg  <= held_keep_next;
      held_valid_reg <= held_valid_next;
      cnt_reg        <= cnt_next;
      if (i_rx_valid) begin
        prev_data_reg <= i_rxd[63:32];
        prev_ctl_reg  <= i_rxctl[7:4];
      end
    end
  end

  // Registered output beat.
  always_ff @(posedge i_rxc or posedge i_rx_reset) begin
    if (i_rx_reset) begin
      tdata_reg  <= 64'd0;
      tkeep_reg  <= 8'd0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      tuser_reg  <= 1'b0;
    end else begin
      tdata_reg  <= tdata_next;
      tkeep_reg  <= tkeep_next;
      tvalid_reg <= tvalid_next;
      tlast_reg  <= tlast_next;
      tuser_reg  <= tuser_next;
    end
  end

  assign o_tdata  = tdata_reg;
  assign o_tkeep  = tkeep_reg;
  assign o_tvalid = tvalid_reg;
  assign o_tlast  = tlast_reg;
  assign o_tuser  = tuser_reg;

endmodule

// File: tb/tb_xgmii_rx_framer.sv
// Directed bench for xgmii_rx_framer: a vector table of input words with the
// beat expected after each clock, plus hand-written reset sequences.
module tb_xgmii_rx_framer;

  logic        clk;
  logic        rst;
  logic [63:0] rxd;
  logic [7:0]  rxctl;
  logic        rx_valid;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;

  int total_cnt;
  int pass_cnt;

  xgmii_rx_framer #(.MAX_FRAME_BEATS(4)) dut (
    .i_rxc      (clk),
    .i_rx_reset (rst),
    .i_rxd      (rxd),
    .i_rxctl    (rxctl),
    .i_rx_valid (rx_valid),
    .o_tdata    (tdata),
    .o_tkeep    (tkeep),
    .o_tvalid   (tvalid),
    .o_tlast    (tlast),
    .o_tuser    (tuser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [63:0] rxd;
    logic [7:0]  ctl;
    logic        ev;
    logic [63:0] ed;
    logic [7:0]  ek;
    logic        el;
    logic        eu;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] IDLE_W  = 64'h0707_0707_0707_0707;
  localparam logic [63:0] START_W = 64'hD555_5555_5555_55FB;
  localparam logic [63:0] TERM_W  = 64'h0707_0707_0707_07FD;

  task automatic add_q(input logic v, input logic [63:0] d, input logic [7:0] c);
    vec_t x;
    x.valid = v; x.rxd = d; x.ctl = c;
    x.ev = 1'b0; x.ed = 64'd0; x.ek = 8'd0; x.el = 1'b0; x.eu = 1'b0;
    vecs.push_back(x);
  endtask

  task automatic add_b(input logic v, input logic [63:0] d, input logic [7:0] c,
                       input logic [63:0] ed, input logic [7:0] ek,
                       input logic el, input logic eu);
    vec_t x;
    x.valid = v; x.rxd = d; x.ctl = c;
    x.ev = 1'b1; x.ed = ed; x.ek = ek; x.el = el; x.eu = eu;
    vecs.push_back(x);
  endtask

  task automatic check_beat(input string name, input logic ev, input logic [63:0] ed,
                            input logic [7:0] ek, input logic el, input logic eu);
    logic bad;
    total_cnt++;
    bad = (tvalid !== ev);
    if (ev && ((tdata !== ed) || (tkeep !== ek) || (tlast !== el) || (tuser !== eu)))
      bad = 1'b1;
    if (bad)
      $display("FAIL %s: got v=%0b d=%h k=%h l=%0b u=%0b, expected v=%0b d=%h k=%h l=%0b u=%0b",
               name, tvalid, tdata, tkeep, tlast, tuser, ev, ed, ek, el, eu);
    else begin
      pass_cnt++;
      $display("ok   %s: v=%0b d=%h k=%h l=%0b u=%0b", name, tvalid, tdata, tkeep, tlast, tuser);
    end
  endtask

  task automatic check_zero(input string name);
    total_cnt++;
    if ({tdata, tkeep, tvalid, tlast, tuser} !== 75'd0)
      $display("FAIL %s: got d=%h k=%h v=%0b l=%0b u=%0b, expected all zero",
               name, tdata, tkeep, tvalid, tlast, tuser);
    else begin
      pass_cnt++;
      $display("ok   %s: outputs zero", name);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] c);
    @(negedge clk);
    rx_valid = v; rxd = d; rxctl = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    rst = 1'b1; rx_valid = 1'b0; rxd = 64'd0; rxctl = 8'd0;

    // Basic frame, beat-aligned terminate.
    add_q(1, IDLE_W, 8'hFF);
    add_q(1, START_W, 8'h01);
    add_q(1, 64'h1111_1111_1111_1111, 8'h00);
    add_b(1, 64'h2222_2222_2222_2222, 8'h00, 64'h1111_1111_1111_1111, 8'hFF, 0, 0);
    add_b(1, TERM_W, 8'hFF, 64'h2222_2222_2222_2222, 8'hFF, 1, 0);
    add_q(1, IDLE_W, 8'hFF);
    // Partial tail: terminate at lane 3.
    add_q(1, START_W, 8'h01);
    add_q(1, 64'h0123_4567_89AB_CDEF, 8'h00);
    add_b(1, 64'h0707_0707_FDC3_B2A1, 8'hF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0);
    add_b(1, IDLE_W, 8'hFF, 64'h0000_0000_00C3_B2A1, 8'h07, 1, 0);
    add_q(1, IDLE_W, 8'hFF);
    // Start in lane 4.
    add_q(1, 64'h5555_55FB_0707_0707, 8'h1F);
    add_q(1, 64'h1312_1110_D555_5555, 8'h00);
    add_q(1, 64'h2726_2524_2322_2120, 8'h00);
    add_b(1, TERM_W, 8'hFF, 64'h2322_2120_1312_1110, 8'hFF, 0, 0);
    add_b(1, IDLE_W, 8'hFF, 64'h0000_0000_2726_2524, 8'h0F, 1, 0);
    add_q(1, IDLE_W, 8'hFF);
    // Error character mid-frame, following data ignored.
    add_q(1, START_W, 8'h01);
    add_q(1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00);
    add_b(1, 64'h0000_0000_00FE_0000, 8'h04, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1, 1);
    add_q(1, 64'hCCCC_CCCC_CCCC_CCCC, 8'h00);
    add_q(1, 64'hCCCC_CCCC_CCCC_CCCC, 8'h00);
    add_q(1, IDLE_W, 8'hFF);
    // Gearbox gaps between words; the invalid words carry garbage.
    add_q(1, START_W, 8'h01);
    add_q(1, 64'h3131_3131_3131_3131, 8'h00);
    add_q(0, 64'hFEFE_FEFE_FEFE_FEFE, 8'hFF);
    add_b(1, 64'h3232_3232_3232_3232, 8'h00, 64'h3131_3131_3131_3131, 8'hFF, 0, 0);
    add_q(0, TERM_W, 8'hFF);
    add_b(1, TERM_W, 8'hFF, 64'h3232_3232_3232_3232, 8'hFF, 1, 0);
    // Zero-data frame.
    add_q(1, START_W, 8'h01);
    add_q(1, TERM_W, 8'hFF);
    add_q(1, IDLE_W, 8'hFF);
    // Tail flushed during a gap, then a back-to-back start in the flush cycle.
    add_q(1, START_W, 8'h01);
    add_q(1, 64'h7777_7777_7777_7777, 8'h00);
    add_b(1, 64'h0707_0707_0707_FD78, 8'hFE, 64'h7777_7777_7777_7777, 8'hFF, 0, 0);
    add_b(0, 64'hFEFE_FEFE_FEFE_FEFE, 8'hFF, 64'h0000_0000_0000_0078, 8'h01, 1, 0);
    add_q(1, START_W, 8'h01);
    add_q(1, 64'h8888_8888_8888_8888, 8'h00);
    add_b(1, 64'h0707_07FD_8989_8989, 8'hF0, 64'h8888_8888_8888_8888, 8'hFF, 0, 0);
    add_b(1, START_W, 8'h01, 64'h0000_0000_8989_8989, 8'h0F, 1, 0);
    add_q(1, 64'h9999_9999_9999_9999, 8'h00);
    add_b(1, TERM_W, 8'hFF, 64'h9999_9999_9999_9999, 8'hFF, 1, 0);
    // Oversize with a limit of 4 beats: 6 data words.
    add_q(1, START_W, 8'h01);
    add_q(1, 64'h4141_4141_4141_4141, 8'h00);
    add_b(1, 64'h4242_4242_4242_4242, 8'h00, 64'h4141_4141_4141_4141, 8'hFF, 0, 0);
    add_b(1, 64'h4343_4343_4343_4343, 8'h00, 64'h4242_4242_4242_4242, 8'hFF, 0, 0);
    add_b(1, 64'h4444_4444_4444_4444, 8'h00, 64'h4343_4343_4343_4343, 8'hFF, 0, 0);
    add_b(1, 64'h4545_4545_4545_4545, 8'h00, 64'h4444_4444_4444_4444, 8'hFF, 1, 1);
    add_q(1, 64'h4646_4646_4646_4646, 8'h00);
    add_q(1, TERM_W, 8'hFF);
    add_q(1, IDLE_W, 8'hFF);
    // Exactly 4 beats is not oversize; also recovery after discard.
    add_q(1, START_W, 8'h01);
    add_q(1, 64'h5151_5151_5151_5151, 8'h00);
    add_b(1, 64'h5252_5252_5252_5252, 8'h00, 64'h5151_5151_5151_5151, 8'hFF, 0, 0);
    add_b(1, 64'h5353_5353_5353_5353, 8'h00, 64'h5252_5252_5252_5252, 8'hFF, 0, 0);
    add_b(1, 64'h5454_5454_5454_5454, 8'h00, 64'h5353_5353_5353_5353, 8'hFF, 0, 0);
    add_b(1, TERM_W, 8'hFF, 64'h5454_5454_5454_5454, 8'hFF, 1, 0);
    add_q(1, IDLE_W, 8'hFF);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].valid, vecs[i].rxd, vecs[i].ctl);
      check_beat($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ek,
                 vecs[i].el, vecs[i].eu);
    end

    // Reset mid-frame: outputs clear at once, partial frame never closes.
    drive(1, START_W, 8'h01);
    drive(1, 64'h6161_6161_6161_6161, 8'h00);
    drive(1, 64'h6262_6262_6262_6262, 8'h00);
    check_beat("pre_reset_beat", 1, 64'h6161_6161_6161_6161, 8'hFF, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    drive(1, TERM_W, 8'hFF);
    check_beat("no_tlast_after_reset", 0, 64'd0, 8'd0, 0, 0);
    drive(1, START_W, 8'h01);
    check_beat("restart_start", 0, 64'd0, 8'd0, 0, 0);
    drive(1, 64'h6363_6363_6363_6363, 8'h00);
    check_beat("restart_hold", 0, 64'd0, 8'd0, 0, 0);
    drive(1, 64'h0707_0707_0707_FD64, 8'hFE);
    check_beat("restart_full", 1, 64'h6363_6363_6363_6363, 8'hFF, 0, 0);
    drive(1, IDLE_W, 8'hFF);
    check_beat("restart_tail", 1, 64'h0000_0000_0000_0064, 8'h01, 1, 0);
    drive(1, IDLE_W, 8'hFF);
    check_beat("restart_quiet", 0, 64'd0, 8'd0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/xgmii_rx_framer.md
XGMII_RX_FRAMER -- requirements
Module: xgmii_rx_framer

Interface
REQ-001 The block SHALL have parameter MAX_FRAME_BEATS, default 192, the maximum number of output beats per frame.
REQ-002 The block SHALL have port i_rxc, input, 1 bit, the receive clock; one clock only.
REQ-003 The block SHALL have port i_rx_reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port i_rxd, input, 64 bits, decoded XGMII data; lane i = bits [8i+7:8i], and lane 0 is the first byte on the wire.
REQ-005 The block SHALL have port i_rxctl, input, 8 bits, XGMII control flags; bit i marks lane i as a control character.
REQ-006 The block SHALL have port i_rx_valid, input, 1 bit, word-valid qualifier from the PCS; it drops during gearbox gaps.
REQ-007 The block SHALL have port o_tdata, output, 64 bits, frame payload; lane mapping is the same as i_rxd.
REQ-008 The block SHALL have port o_tkeep, output, 8 bits, byte enables; always contiguous from bit 0.
REQ-009 The block SHALL have port o_tvalid, output, 1 bit, beat valid; there is no backpressure (no ready input).
REQ-010 The block SHALL have port o_tlast, output, 1 bit, marks the final beat of a frame.
REQ-011 The block SHALL have port o_tuser, output, 1 bit, frame-error flag; it is only meaningful when o_tlast=1.

Function
REQ-012 Words with i_rx_valid=0 SHALL be ignored entirely: no state change, and no output except as stated in REQ-021.
REQ-013 A prev register SHALL hold i_rxd[63:32] and i_rxctl[7:4] of the last valid word.
REQ-014 The aligned word A SHALL be the current word in mode 0, and {cur[31:0], prev[63:32]} (ctl likewise) in mode 4.
REQ-015 A start word SHALL be: lane 0 = 0xFB with ctl=1; lanes 1-6 = 0x55 with ctl=0; lane 7 = 0xD5 with ctl=0.
REQ-016 The FSM SHALL have states IDLE, DATA, FLUSH and DISCARD.
REQ-017 In IDLE:
- current word is a start word -> mode 0, go to DATA;
- else {cur[31:0], prev[63:32]} is a start word -> mode 4, go to DATA;
- else stay in IDLE, with no output.
REQ-018 In DATA, a valid A with no ctl bits set SHALL become the held beat (keep 0xFF), and any previously held beat SHALL be emitted with tlast=0.
REQ-019 In DATA, if A has lowest ctl lane k with A lane k = 0xFD (terminate):
- k=0: the held beat is emitted with tlast=1, then go to IDLE;
- k>0: the held beat is emitted with tlast=0, A lanes 0..k-1 become the held beat with keep = 2^k-1, then go to FLUSH.
REQ-020 In DATA, a ctl lane holding any character other than 0xFD SHALL cause the held beat to be emitted with tlast=1 and tuser=1, then go to IDLE.
REQ-021 FLUSH SHALL emit the held beat with tlast=1 on the next clock regardless of i_rx_valid, and SHALL apply IDLE start detection to that same cycle's word.
REQ-022 Zero-data frames (terminate at lane 0 with nothing held) SHALL emit nothing and return to IDLE.
REQ-023 Oversize: when the frame's beat count would exceed MAX_FRAME_BEATS, the held beat SHALL be emitted with tlast=1 and tuser=1, and the FSM SHALL enter DISCARD.
REQ-024 DISCARD SHALL stay there, with no output, until a valid word contains any ctl bit; the FSM then goes to IDLE and applies start detection to that word.
REQ-025 Outputs SHALL be registered; a beat appears on the clock edge after the valid word that determines its tlast.
REQ-026 o_tvalid SHALL be a single-cycle pulse per beat.
REQ-027 o_tdata lanes whose o_tkeep bit is 0 SHALL be driven to zero.
REQ-028 o_tuser SHALL be 0 on beats with tlast=0.
REQ-029 The beat counter SHALL be 8 bits wide, SHALL saturate, and SHALL clear on entry to DATA.

Reset
REQ-030 On i_rx_reset=1, asynchronously:
- FSM goes to IDLE, mode goes to 0;
- prev, held beat and counter clear to 0;
- o_tdata=0, o_tkeep=0, o_tvalid=0, o_tlast=0, o_tuser=0.
REQ-031 Reset mid-frame SHALL discard the partial frame with no tlast emitted; after reset is released, the next start word SHALL be received normally.

Verification
REQ-032 Mode-0 start, then data 0x1111..., then 0x2222..., then FD@lane0 -> beat 0x1111... keep FF tlast0; beat 0x2222... keep FF tlast1 tuser0.
REQ-033 Mode-0 start, data D, then word {lanes0-2 = a,b,c; FD@lane3; 07 idles} -> beat D keep FF tlast0; next clock beat {c,b,a} keep 0x07 tlast1.
REQ-034 Mode-4 start: W0 = {idles, FB 55 55 55}, W1 = {55 55 55 D5, d0-d3}, W2 = e0-e7, W3 = FD@0 -> beat {d0-d3, e0-e3} keep FF tlast0; then {e4-e7} keep 0x0F tlast1.
REQ-035 0xFE with ctl at lane 2 mid-frame -> held beat emitted tlast1 tuser1; subsequent data words produce no output until a new start.
REQ-036 i_rx_valid=0 for one cycle between data words -> no output that cycle, all bytes delivered in order; MAX_FRAME_BEATS=4 with a 6-word frame -> 4th beat tlast1 tuser1, nothing further.
